// File: rtl/fpu_issue_queue_if.sv
// Handshake bundle for fpu_issue_queue: operation input, fpu operand/result link, result output.
// out_flags exists only when FPU_ISSUE_FLAGS_EN is defined.
interface fpu_issue_queue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_op;
`ifdef FPU_ISSUE_FLAGS_EN
  logic [2:0]       out_flags;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, fpu_o, out_ready,
    input  in_ready, fpu_a, fpu_b, fpu_opcode, out_valid, out_data, out_tag, out_op
`ifdef FPU_ISSUE_FLAGS_EN
    , input out_flags
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, fpu_o, out_ready,
    output in_ready, fpu_a, fpu_b, fpu_opcode, out_valid, out_data, out_tag, out_op
`ifdef FPU_ISSUE_FLAGS_EN
    , output out_flags
`endif
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// Issue sequencer in front of a one-cycle fpu: input FIFO, credit-gated issue, in-order result FIFO.
// Optional result classification flags are built with FPU_ISSUE_FLAGS_EN.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  fpu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef FPU_ISSUE_FLAGS_EN
  function automatic logic [2:0] fp_flags(input logic [31:0] w);
    logic exp_max, exp_zero, frac_zero;
    exp_max   = (w[30:23] == 8'hFF);
    exp_zero  = (w[30:23] == 8'h00);
    frac_zero = (w[22:0] == 23'd0);
    return {exp_max & ~frac_zero, exp_max & frac_zero, exp_zero & frac_zero};
  endfunction
`endif

  logic [31:0]      ia_q   [DEPTH];
  logic [31:0]      ib_q   [DEPTH];
  logic [1:0]       iop_q  [DEPTH];
  logic [TAG_W-1:0] itag_q [DEPTH];
  logic [AW-1:0]    iwr_q, iwr_d, ird_q, ird_d;
  logic [CW-1:0]    icnt_q, icnt_d;
  logic             live_q, push, issue;

  logic [31:0]      fpu_a_q, fpu_b_q;
  logic [1:0]       fpu_op_q;
  logic             vld_p0_q, vld_p1_q;
  logic [TAG_W-1:0] tag_p0_q, tag_p1_q;
  logic [1:0]       op_p0_q, op_p1_q;

  logic [31:0]      rdata_q [4];
  logic [TAG_W-1:0] rtag_q  [4];
  logic [1:0]       rop_q   [4];
`ifdef FPU_ISSUE_FLAGS_EN
  logic [2:0]       rflags_q [4];
`endif
  logic [1:0]       rwr_q, rwr_d, rrd_q, rrd_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic             rvld, rpop;

  // in_ready is held low until one edge after reset release; no bypass when full.
  assign bus.in_ready   = live_q && (icnt_q < FULL);
  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.fpu_opcode = fpu_op_q;
  assign rvld           = (rcnt_q != 3'd0);
  assign rpop           = rvld && bus.out_ready;

  always_comb begin
    push   = bus.in_valid && bus.in_ready;
    // Credit: results held plus both in-flight stages must leave room for one more.
    issue  = (icnt_q != '0) && ((rcnt_q + {2'b00, vld_p0_q} + {2'b00, vld_p1_q}) < 3'd4);
    iwr_d  = push  ? iwr_q + AW'(1) : iwr_q;
    ird_d  = issue ? ird_q + AW'(1) : ird_q;
    icnt_d = icnt_q;
    if (push && !issue)      icnt_d = icnt_q + CW'(1);
    else if (!push && issue) icnt_d = icnt_q - CW'(1);
    rwr_d  = vld_p1_q ? rwr_q + 2'd1 : rwr_q;
    rrd_d  = rpop ? rrd_q + 2'd1 : rrd_q;
    rcnt_d = rcnt_q;
    if (vld_p1_q && !rpop)      rcnt_d = rcnt_q + 3'd1;
    else if (!vld_p1_q && rpop) rcnt_d = rcnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      iwr_q    <= '0;
      ird_q    <= '0;
      icnt_q   <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      fpu_a_q  <= '0;
      fpu_b_q  <= '0;
      fpu_op_q <= 2'b00;
      rwr_q    <= '0;
      rrd_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      live_q   <= 1'b1;
      iwr_q    <= iwr_d;
      ird_q    <= ird_d;
      icnt_q   <= icnt_d;
      // p0: issue into fpu operand registers
      vld_p0_q <= issue;
      if (issue) begin
        fpu_a_q  <= ia_q[ird_q];
        fpu_b_q  <= ib_q[ird_q];
        fpu_op_q <= iop_q[ird_q];
      end
      // p1: fpu result registered, captured on the following edge
      vld_p1_q <= vld_p0_q;
      rwr_q    <= rwr_d;
      rrd_q    <= rrd_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ia_q[iwr_q]   <= bus.in_a;
      ib_q[iwr_q]   <= bus.in_b;
      iop_q[iwr_q]  <= bus.in_op;
      itag_q[iwr_q] <= bus.in_tag;
    end
    if (issue) begin
      tag_p0_q <= itag_q[ird_q];
      op_p0_q  <= iop_q[ird_q];
    end
    tag_p1_q <= tag_p0_q;
    op_p1_q  <= op_p0_q;
    if (vld_p1_q) begin
      rdata_q[rwr_q]  <= bus.fpu_o;
      rtag_q[rwr_q]   <= tag_p1_q;
      rop_q[rwr_q]    <= op_p1_q;
`ifdef FPU_ISSUE_FLAGS_EN
      rflags_q[rwr_q] <= fp_flags(bus.fpu_o);
`endif
    end
  end

  always_comb begin
    bus.out_valid = rvld;
    bus.out_data  = '0;
    bus.out_tag   = '0;
    bus.out_op    = 2'b00;
`ifdef FPU_ISSUE_FLAGS_EN
    bus.out_flags = 3'b000;
`endif
    if (rvld) begin
      bus.out_data  = rdata_q[rrd_q];
      bus.out_tag   = rtag_q[rrd_q];
      bus.out_op    = rop_q[rrd_q];
`ifdef FPU_ISSUE_FLAGS_EN
      bus.out_flags = rflags_q[rrd_q];
`endif
    end
  end
endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Front-end sequencer that sits directly upstream of the single-precision `fpu` and also collects its results. It accepts tagged operations over a valid/ready handshake and buffers them in an input FIFO. It issues at most one operation per cycle into the `fpu`'s operand/opcode inputs, tracks the `fpu`'s one-cycle registered latency, and captures each result in order into a result FIFO. That FIFO drives a valid/ready output with the original tag.

## Interface
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the caller-supplied operation tag.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  input FIFO can accept; `count_in < DEPTH`.
- `in_a`, `in_b`  in  32  IEEE 754 single operands.
- `in_op`  in  2  00 add, 01 sub, 10 div, 11 mul (`fpu` encoding).
- `in_tag`  in  TAG_W  returned unchanged with the result.
- `fpu_a`, `fpu_b`  out  32  registered operands to `fpu` A/B.
- `fpu_opcode`  out  2  registered opcode to `fpu`.
- `fpu_o`  in  32  `fpu` output O.
- `out_valid`  out  1  result FIFO non-empty.
- `out_ready`  in  1  consumer accepts head result.
- `out_data`  out  32  result word.
- `out_tag`  out  TAG_W  tag of that result.
- `out_op`  out  2  opcode of that result.
- `out_flags`  out  3  {nan, inf, zero}; present only with `FPU_ISSUE_FLAGS_EN`.

## Operation
- Input FIFO:
  - `DEPTH` entries of {a, b, op, tag}.
  - Push on `in_valid && in_ready`.
  - No push-on-pop bypass: when full, `in_ready` stays low even if a pop occurs that cycle.
- Issue:
  - Pops the FIFO head into the `fpu_a`/`fpu_b`/`fpu_opcode` registers and sets `iss_v` when both hold: FIFO non-empty, and `res_count + iss_v + cap_v < 4`.
  - Otherwise `iss_v` clears and the operand registers hold their value.
  - The issue path does not read an entry in the same cycle it is written.
- Capture:
  - `cap_v <= iss_v`; the tag and op travel alongside in a matching two-stage shift.
  - When `cap_v` is 1, `fpu_o` is written into the result FIFO with its tag and op.
- Result FIFO:
  - Fixed 4 entries.
  - Pop on `out_valid && out_ready`.
  - Simultaneous capture and pop leaves `res_count` unchanged.
- Credit rule: the result FIFO can never overflow. No result is dropped, and results always come out in order.
- Pointers are `log2` width and wrap naturally. Counts are one bit wider.

## Timing
- Accept at edge t with an empty pipeline gives:
  - issue at t+1;
  - `fpu` latch at t+2;
  - capture at t+3;
  - `out_valid` high after t+3.
- Latency is therefore 3 cycles.
- Throughput is 1 op/cycle sustained while `out_ready` is held high.
- With `out_ready` low, at most 4 results plus `DEPTH` queued operations are held. Issue stalls before overflow.
- Reset (`rst_n` low, asynchronous):
  - FIFO counts and pointers = 0, `iss_v` = `cap_v` = 0.
  - `in_ready` = 0 while in reset, 1 on the first cycle after release.
  - `out_valid` = 0; `out_data`, `out_tag`, `out_op`, `out_flags` = 0.
  - `fpu_a` = `fpu_b` = 0, `fpu_opcode` = 00.
- Reset mid-operation discards all queued and in-flight operations. The `fpu`'s internal O is not reset, but is never captured because `cap_v` = 0.

## Configuration
- `FPU_ISSUE_FLAGS_EN` defined:
  - At capture, `out_flags` is computed from `fpu_o` and stored with the result.
  - nan = exp 255 with frac ≠ 0.
  - inf = exp 255 with frac = 0.
  - zero = exp 0 with frac = 0.
- Undefined: the `out_flags` port and its storage are absent; all other behaviour is identical.

## Test plan
- Single add: accept `in_a`=0x3F800000, `in_b`=0x40000000, op 00, tag 5 -> `out_valid` 3 cycles later with `out_data`=0x40400000, `out_tag`=5.
- Multiply stream: 16 back-to-back 0x40000000×0x40400000 ops, op 11, tags 0..15, `out_ready`=1 -> 16 consecutive results of 0x40C00000, tags in order, no bubbles after the 3-cycle fill.
- Backpressure: `out_ready`=0, offer 8 ops -> 4 results held, `in_ready` falls after `DEPTH` queued and the issue stalls; raise `out_ready` -> all 8 results return in tag order with none lost.
- Simultaneous events: full result FIFO with `out_ready` pulsed for one cycle -> exactly one pop, one new issue, counts consistent.
- Reset mid-stream: assert `rst_n` low with 3 ops in flight -> all outputs at reset values; after release, a new op tagged 9 returns alone with tag 9.
- Flags (macro on): 0x7F800000×0x3F800000 op 11 -> `out_data`=0x7F800000, `out_flags`=3'b010; 0x3F800000×0x00000000 -> `out_flags`=3'b001.
